// File: rtl/ofdm_pkg.sv
// Shared fixed-point constants and helpers for the OFDM datapath.
// Twiddles are signed Q1.15 in 17 bits so that +1.0 (32768) is representable.
package ofdm_pkg;
    localparam int TW_WIDTH = 17;
    localparam int TW_FRAC  = 15;
    localparam int TW_ONE   = 32768;

    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // First-quadrant cosine entry i of q steps, rounded to nearest; evaluated at elaboration.
    function automatic logic signed [TW_WIDTH-1:0] tw_entry(input int i, input int q);
        real a;
        a = 1.5707963267948966 * real'(i) / real'(q);
        return TW_WIDTH'($rtoi($cos(a) * real'(TW_ONE) + 0.5));
    endfunction
endpackage

// File: rtl/mult_complex_e_derotate_twiddle_rom.sv
// Registered cos/sin lookup for a SIZE_DATA_FI-bit phase, folded from a
// quarter-wave table of 2^(SIZE_DATA_FI-2)+1 entries.
module twiddle_rom
    import ofdm_pkg::*;
#(
    parameter int SIZE_DATA_FI = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [SIZE_DATA_FI-1:0]    phase,
    output logic signed [TW_WIDTH-1:0] cos_q,
    output logic signed [TW_WIDTH-1:0] sin_q
);
    localparam int P  = SIZE_DATA_FI;
    localparam int Q  = 2 ** (P - 2);
    localparam int IW = $clog2(Q + 1);

    logic signed [TW_WIDTH-1:0] tbl [0:Q];

    for (genvar g = 0; g <= Q; g++) begin : g_tbl
        localparam logic signed [TW_WIDTH-1:0] V = tw_entry(g, Q);
        assign tbl[g] = V;
    end

    logic [1:0]                 quad;
    logic [P-1:0]               r;
    logic [P-1:0]               rc;
    logic signed [TW_WIDTH-1:0] ca;
    logic signed [TW_WIDTH-1:0] sa;
    logic signed [TW_WIDTH-1:0] cos_d;
    logic signed [TW_WIDTH-1:0] sin_d;

    always_comb begin
        quad = 2'(phase >> (P - 2));
        r    = phase & P'(Q - 1);
        rc   = P'(Q) - r;
        ca   = tbl[IW'(r)];
        sa   = tbl[IW'(rc)];
        // Rotate the first-quadrant pair by whole quarter turns.
        unique case (quad)
            2'd0: begin cos_d = ca;  sin_d = sa;  end
            2'd1: begin cos_d = -sa; sin_d = ca;  end
            2'd2: begin cos_d = -ca; sin_d = -sa; end
            default: begin cos_d = sa; sin_d = -ca; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cos_q <= '0;
            sin_q <= '0;
        end else if (en) begin
            cos_q <= cos_d;
            sin_q <= sin_d;
        end
    end
endmodule

// File: rtl/mult_complex_e_derotate.sv
// Streaming derotator: multiplies each sample by e^(+j*2*pi*acc/2^SIZE_DATA_FI),
// acc advancing by step per accepted sample and clearing after in_last.
module mult_complex_e_derotate
    import ofdm_pkg::*;
#(
    parameter int SIZE_DATA    = 16,
    parameter int SIZE_DATA_FI = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SIZE_DATA_FI-1:0]     step,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [SIZE_DATA-1:0] in_data_i,
    input  logic signed [SIZE_DATA-1:0] in_data_q,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [SIZE_DATA-1:0] out_data_i,
    output logic signed [SIZE_DATA-1:0] out_data_q,
    output logic                        out_last
);
    localparam int PW = SIZE_DATA + TW_WIDTH;
    localparam int SW = PW + 1;

    logic                        adv;
    logic                        accept;
    logic [SIZE_DATA_FI-1:0]     acc_q, acc_d;
    logic [3:1]                  vld_q, vld_d;
    logic signed [TW_WIDTH-1:0]  tw_cos, tw_sin;
    logic signed [SIZE_DATA-1:0] xi1_q, xi1_d, xq1_q, xq1_d;
    logic                        last1_q, last1_d, last2_q, last2_d, last3_q, last3_d;
    logic signed [PW-1:0]        p_ic_q, p_ic_d, p_qs_q, p_qs_d;
    logic signed [PW-1:0]        p_is_q, p_is_d, p_qc_q, p_qc_d;
    logic signed [SW-1:0]        sum_i, sum_q;
    logic signed [SIZE_DATA-1:0] oi_q, oi_d, oq_q, oq_d;

    twiddle_rom #(.SIZE_DATA_FI(SIZE_DATA_FI)) u_rom (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .phase (acc_q),
        .cos_q (tw_cos),
        .sin_q (tw_sin)
    );

    always_comb begin
        adv      = out_ready | ~vld_q[3];
        in_ready = adv & ~rst;
        accept   = in_valid & in_ready;

        acc_d = acc_q;
        if (accept) acc_d = in_last ? '0 : acc_q + step;

        sum_i = SW'(p_ic_q) - SW'(p_qs_q);
        sum_q = SW'(p_is_q) + SW'(p_qc_q);

        vld_d   = vld_q;
        xi1_d   = xi1_q;
        xq1_d   = xq1_q;
        last1_d = last1_q;
        p_ic_d  = p_ic_q;
        p_qs_d  = p_qs_q;
        p_is_d  = p_is_q;
        p_qc_d  = p_qc_q;
        last2_d = last2_q;
        oi_d    = oi_q;
        oq_d    = oq_q;
        last3_d = last3_q;
        // One shared enable keeps bubbles in place and makes a stall hold every stage.
        if (adv) begin
            vld_d   = {vld_q[2:1], accept};
            xi1_d   = in_data_i;
            xq1_d   = in_data_q;
            last1_d = in_last;
            p_ic_d  = PW'(xi1_q) * PW'(tw_cos);
            p_qs_d  = PW'(xq1_q) * PW'(tw_sin);
            p_is_d  = PW'(xi1_q) * PW'(tw_sin);
            p_qc_d  = PW'(xq1_q) * PW'(tw_cos);
            last2_d = last1_q;
            oi_d    = SIZE_DATA'(sat_to(64'(sum_i >>> TW_FRAC), SIZE_DATA));
            oq_d    = SIZE_DATA'(sat_to(64'(sum_q >>> TW_FRAC), SIZE_DATA));
            last3_d = last2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            vld_q   <= '0;
            xi1_q   <= '0;
            xq1_q   <= '0;
            last1_q <= 1'b0;
            p_ic_q  <= '0;
            p_qs_q  <= '0;
            p_is_q  <= '0;
            p_qc_q  <= '0;
            last2_q <= 1'b0;
            oi_q    <= '0;
            oq_q    <= '0;
            last3_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            vld_q   <= vld_d;
            xi1_q   <= xi1_d;
            xq1_q   <= xq1_d;
            last1_q <= last1_d;
            p_ic_q  <= p_ic_d;
            p_qs_q  <= p_qs_d;
            p_is_q  <= p_is_d;
            p_qc_q  <= p_qc_d;
            last2_q <= last2_d;
            oi_q    <= oi_d;
            oq_q    <= oq_d;
            last3_q <= last3_d;
        end
    end

    assign out_valid  = vld_q[3];
    assign out_data_i = oi_q;
    assign out_data_q = oq_q;
    assign out_last   = last3_q;
endmodule

// File: tb/tb_mult_complex_e_derotate.sv
// Scoreboard bench for the derotator at SIZE_DATA=16, SIZE_DATA_FI=3.
module tb_mult_complex_e_derotate;
    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        step;
    logic              in_valid, in_ready, in_last;
    logic signed [15:0] in_data_i, in_data_q;
    logic              out_valid, out_ready, out_last;
    logic signed [15:0] out_data_i, out_data_q;

    always #5 clk = ~clk;

    mult_complex_e_derotate #(.SIZE_DATA(16), .SIZE_DATA_FI(3)) dut (
        .clk(clk), .rst(rst), .step(step),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data_i(in_data_i), .in_data_q(in_data_q), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data_i(out_data_i), .out_data_q(out_data_q), .out_last(out_last)
    );

    typedef struct { logic signed [15:0] i; logic signed [15:0] q; logic l; } exp_t;
    exp_t sb[$];
    int cos_t[8] = '{32768, 23170, 0, -23170, -32768, -23170, 0, 23170};
    int sin_t[8] = '{0, 23170, 32768, 23170, 0, -23170, -32768, -23170};
    int m_acc = 0;
    int n_chk = 0;
    int n_err = 0;
    logic obs_acc, obs_xfer, obs_valid, obs_rdy, obs_last;
    logic signed [15:0] obs_i, obs_q;

    function automatic logic signed [15:0] sat16(input longint v);
        if (v > 32767) return 16'sh7fff;
        if (v < -32768) return 16'sh8000;
        return v[15:0];
    endfunction

    // Drive one cycle, observe mid-cycle, and feed the reference model on accepts.
    task automatic step_cycle(input logic v, input logic signed [15:0] xi, input logic signed [15:0] xq,
                              input logic l, input logic [2:0] st, input logic ordy, input logic r);
        exp_t e;
        longint c, s;
        rst = r; in_valid = v; in_data_i = xi; in_data_q = xq; in_last = l; step = st; out_ready = ordy;
        #1;
        obs_acc = in_valid & in_ready;
        obs_valid = out_valid;
        obs_xfer = out_valid & out_ready & ~r;
        obs_rdy = in_ready;
        obs_i = out_data_i; obs_q = out_data_q; obs_last = out_last;
        if (r) begin
            m_acc = 0;
            sb.delete();
        end else if (obs_acc) begin
            c = longint'(cos_t[m_acc]);
            s = longint'(sin_t[m_acc]);
            e.i = sat16((longint'(xi) * c - longint'(xq) * s) >>> 15);
            e.q = sat16((longint'(xi) * s + longint'(xq) * c) >>> 15);
            e.l = l;
            sb.push_back(e);
            m_acc = l ? 0 : (m_acc + int'(st)) % 8;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        step_cycle(0, 0, 0, 0, 0, 1, 1);
        step_cycle(0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", obs_valid); end
        n_chk++; if (obs_i !== 16'sd0 || obs_q !== 16'sd0) begin n_err++; $display("FAIL reset_out_data got %0d,%0d want 0,0", obs_i, obs_q); end
        n_chk++; if (obs_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got %b want 0", obs_last); end
        n_chk++; if (obs_rdy !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", obs_rdy); end
        step_cycle(0, 0, 0, 0, 0, 1, 0);
        n_chk++; if (obs_rdy !== 1'b1 || obs_valid !== 1'b0) begin n_err++; $display("FAIL reset_release rdy=%b vld=%b want 1,0", obs_rdy, obs_valid); end
    endtask

    task automatic test_rot90();
        exp_t e;
        int first_acc, first_ov, k;
        logic signed [15:0] gi[3], gq[3];
        logic signed [15:0] wi[3] = '{16'sd749, -16'sd749, -16'sd749};
        logic signed [15:0] wq[3] = '{16'sd749, 16'sd749, -16'sd749};
        apply_reset();
        first_acc = -1; first_ov = -1; k = 0;
        for (int c = 0; c < 10; c++) begin
            step_cycle(c < 3, 16'sd749, 16'sd749, 0, 3'd2, 1, 0);
            if (obs_acc && first_acc < 0) first_acc = c;
            if (obs_valid && first_ov < 0) first_ov = c;
            if (obs_xfer) begin
                n_chk++;
                if (sb.size() == 0) begin n_err++; $display("FAIL rot90_out unexpected i=%0d q=%0d", obs_i, obs_q); end
                else begin
                    e = sb.pop_front();
                    if ({obs_i, obs_q, obs_last} !== {e.i, e.q, e.l}) begin
                        n_err++; $display("FAIL rot90_out got %0d,%0d,%b want %0d,%0d,%b", obs_i, obs_q, obs_last, e.i, e.q, e.l);
                    end
                end
                if (k < 3) begin gi[k] = obs_i; gq[k] = obs_q; end
                k++;
            end
        end
        n_chk++; if (first_ov - first_acc != 3) begin n_err++; $display("FAIL rot90_latency got %0d want 3", first_ov - first_acc); end
        n_chk++; if (k != 3) begin n_err++; $display("FAIL rot90_count got %0d want 3", k); end
        for (int j = 0; j < 3 && j < k; j++) begin
            n_chk++;
            if (gi[j] !== wi[j] || gq[j] !== wq[j]) begin n_err++; $display("FAIL rot90_const[%0d] got %0d,%0d want %0d,%0d", j, gi[j], gq[j], wi[j], wq[j]); end
        end
    endtask

    task automatic test_rot45_sat();
        exp_t e;
        int k;
        logic signed [15:0] si[6] = '{16'sd749, 16'sd749, 16'sd0, 16'sd32767, 16'sd0, -16'sd32768};
        logic               sl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic signed [15:0] gi[6], gq[6];
        apply_reset();
        k = 0;
        for (int c = 0; c < 14; c++) begin
            step_cycle(c < 6, (c < 6) ? si[c % 6] : 16'sd0, (c < 6) ? si[c % 6] : 16'sd0, (c < 6) ? sl[c % 6] : 1'b0, 3'd1, 1, 0);
            if (obs_xfer) begin
                n_chk++;
                if (sb.size() == 0) begin n_err++; $display("FAIL rot45_out unexpected i=%0d q=%0d", obs_i, obs_q); end
                else begin
                    e = sb.pop_front();
                    if ({obs_i, obs_q, obs_last} !== {e.i, e.q, e.l}) begin
                        n_err++; $display("FAIL rot45_out got %0d,%0d,%b want %0d,%0d,%b", obs_i, obs_q, obs_last, e.i, e.q, e.l);
                    end
                end
                if (k < 6) begin gi[k] = obs_i; gq[k] = obs_q; end
                k++;
            end
        end
        n_chk++;
        if (k != 6) begin n_err++; $display("FAIL rot45_count got %0d want 6", k); end
        else begin
            n_chk++; if (gi[1] !== 16'sd0 || gq[1] !== 16'sd1059) begin n_err++; $display("FAIL rot45_749 got %0d,%0d want 0,1059", gi[1], gq[1]); end
            n_chk++; if (gi[3] !== 16'sd0 || gq[3] !== 16'sd32767) begin n_err++; $display("FAIL sat_pos got %0d,%0d want 0,32767", gi[3], gq[3]); end
            n_chk++; if (gi[5] !== 16'sd0 || gq[5] !== -16'sd32768) begin n_err++; $display("FAIL sat_neg got %0d,%0d want 0,-32768", gi[5], gq[5]); end
        end
    endtask

    task automatic test_last();
        exp_t e;
        int k;
        logic signed [15:0] xi[4] = '{16'sd1000, 16'sd500, -16'sd1200, 16'sd300};
        logic signed [15:0] xq[4] = '{-16'sd300, 16'sd200, 16'sd700, 16'sd300};
        logic gl[4];
        logic signed [15:0] g2i, g2q;
        apply_reset();
        k = 0; g2i = 0; g2q = 0;
        for (int c = 0; c < 12; c++) begin
            step_cycle(c < 4, xi[c % 4], xq[c % 4], c == 1, 3'd2, 1, 0);
            if (obs_xfer) begin
                n_chk++;
                if (sb.size() == 0) begin n_err++; $display("FAIL last_out unexpected i=%0d q=%0d", obs_i, obs_q); end
                else begin
                    e = sb.pop_front();
                    if ({obs_i, obs_q, obs_last} !== {e.i, e.q, e.l}) begin
                        n_err++; $display("FAIL last_out got %0d,%0d,%b want %0d,%0d,%b", obs_i, obs_q, obs_last, e.i, e.q, e.l);
                    end
                end
                if (k < 4) gl[k] = obs_last;
                if (k == 2) begin g2i = obs_i; g2q = obs_q; end
                k++;
            end
        end
        n_chk++;
        if (k != 4) begin n_err++; $display("FAIL last_count got %0d want 4", k); end
        else begin
            n_chk++; if ({gl[0], gl[1], gl[2], gl[3]} !== 4'b0100) begin n_err++; $display("FAIL last_flags got %b%b%b%b want 0100", gl[0], gl[1], gl[2], gl[3]); end
            n_chk++; if (g2i !== -16'sd1200 || g2q !== 16'sd700) begin n_err++; $display("FAIL last_acc0 got %0d,%0d want -1200,700", g2i, g2q); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int acc_n, cyc;
        logic pend_v, pend_l, ordy, prev_stall;
        logic signed [15:0] pi, pq, prev_i, prev_q;
        logic prev_l;
        logic [2:0] pst;
        apply_reset();
        acc_n = 0; cyc = 0; pend_v = 0; prev_stall = 0;
        pi = 0; pq = 0; pl_init: pend_l = 0; pst = 0;
        prev_i = 0; prev_q = 0; prev_l = 0;
        while ((acc_n < 64 || sb.size() != 0) && cyc < 2000) begin
            if (!pend_v && acc_n < 64 && $urandom_range(0, 3) != 0) begin
                pend_v = 1;
                pi = 16'($urandom); pq = 16'($urandom);
                pend_l = ($urandom_range(0, 7) == 0);
                pst = 3'($urandom);
            end
            ordy = (acc_n >= 64) ? 1'b1 : ($urandom_range(0, 2) != 0);
            step_cycle(pend_v, pi, pq, pend_l, pst, ordy, 0);
            if (obs_acc) begin pend_v = 0; acc_n++; end
            n_chk++;
            if (obs_rdy !== !(obs_valid && !ordy)) begin n_err++; $display("FAIL bp_in_ready got %b vld=%b ordy=%b", obs_rdy, obs_valid, ordy); end
            if (prev_stall) begin
                n_chk++;
                if (obs_valid !== 1'b1 || obs_i !== prev_i || obs_q !== prev_q || obs_last !== prev_l) begin
                    n_err++; $display("FAIL bp_stable got %b %0d,%0d,%b want 1 %0d,%0d,%b", obs_valid, obs_i, obs_q, obs_last, prev_i, prev_q, prev_l);
                end
            end
            prev_stall = obs_valid && !ordy;
            prev_i = obs_i; prev_q = obs_q; prev_l = obs_last;
            if (obs_xfer) begin
                n_chk++;
                if (sb.size() == 0) begin n_err++; $display("FAIL bp_out unexpected i=%0d q=%0d", obs_i, obs_q); end
                else begin
                    e = sb.pop_front();
                    if ({obs_i, obs_q, obs_last} !== {e.i, e.q, e.l}) begin
                        n_err++; $display("FAIL bp_out got %0d,%0d,%b want %0d,%0d,%b", obs_i, obs_q, obs_last, e.i, e.q, e.l);
                    end
                end
            end
            cyc++;
        end
        n_chk++; if (acc_n != 64 || sb.size() != 0) begin n_err++; $display("FAIL bp_drain accepted=%0d pending=%0d want 64,0", acc_n, sb.size()); end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        int k;
        logic signed [15:0] g0i, g0q;
        apply_reset();
        for (int c = 0; c < 3; c++) step_cycle(1, 16'sd100 * 16'(c + 1), 16'sd50, 0, 3'd3, 1, 0);
        step_cycle(0, 0, 0, 0, 3'd3, 1, 1);
        for (int c = 0; c < 4; c++) begin
            step_cycle(0, 0, 0, 0, 3'd1, 1, 0);
            n_chk++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL midrst_quiet[%0d] got out_valid=%b want 0", c, obs_valid); end
        end
        k = 0; g0i = 0; g0q = 0;
        for (int c = 0; c < 8; c++) begin
            step_cycle(c == 0, 16'sd749, -16'sd321, 0, 3'd1, 1, 0);
            if (obs_xfer) begin
                n_chk++;
                if (sb.size() == 0) begin n_err++; $display("FAIL midrst_out unexpected i=%0d q=%0d", obs_i, obs_q); end
                else begin
                    e = sb.pop_front();
                    if ({obs_i, obs_q, obs_last} !== {e.i, e.q, e.l}) begin
                        n_err++; $display("FAIL midrst_out got %0d,%0d,%b want %0d,%0d,%b", obs_i, obs_q, obs_last, e.i, e.q, e.l);
                    end
                end
                if (k == 0) begin g0i = obs_i; g0q = obs_q; end
                k++;
            end
        end
        n_chk++; if (k != 1 || g0i !== 16'sd749 || g0q !== -16'sd321) begin n_err++; $display("FAIL midrst_acc0 count=%0d got %0d,%0d want 1 749,-321", k, g0i, g0q); end
    endtask

    initial begin
        rst = 1; step = 0; in_valid = 0; in_data_i = 0; in_data_q = 0; in_last = 0; out_ready = 1;
        @(negedge clk);
        test_reset();
        test_rot90();
        test_rot45_sat();
        test_last();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end
endmodule
